// File: rtl/u_seqdiv16_8_restoring.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Divide-by-zero and quotient overflow are detected at accept time and bypass the iteration.
//
// state  | meaning
// S_IDLE | in_ready high, waiting for an operand pair
// S_CALC | one restoring iteration per cycle, quotient bits enter MSB first
// S_DONE | result held on out_valid until the consumer takes it
module u_seqdiv16_8_restoring #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           div_by_zero,
   output logic           overflow
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [N-1:0]  dvsr;
   logic [N-1:0]  rem_part;
   logic [N-1:0]  lo_sr;
   logic [CW-1:0] cnt;
   logic          hi_ovf;
   logic [N:0]    shifted;
   logic          take;
   logic [N-1:0]  rem_nxt;

   assign hi_ovf = (dividend[2*N-1:N] >= divisor);

   // Partial remainder stays below the divisor, so its top bit is always zero and
   // only the low N bits are stored; the shifted value needs the extra bit.
   assign shifted = {rem_part, lo_sr[N-1]};
   assign take    = (shifted >= {1'b0, dvsr});
   assign rem_nxt = take ? (shifted[N-1:0] - dvsr) : shifted[N-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if ((divisor == '0) || hi_ovf) state_nxt = S_DONE;
               else                           state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            if (cnt == '0) state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvsr        <= '0;
         rem_part    <= '0;
         lo_sr       <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  dvsr        <= divisor;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend[N-1:0];
                     div_by_zero <= 1'b1;
                  end else if (hi_ovf) begin
                     quotient  <= '1;
                     remainder <= '1;
                     overflow  <= 1'b1;
                  end else begin
                     rem_part <= dividend[2*N-1:N];
                     lo_sr    <= dividend[N-1:0];
                     cnt      <= CW'(N - 1);
                     quotient <= '0;
                  end
               end
            end
            S_CALC: begin
               rem_part <= rem_nxt;
               lo_sr    <= {lo_sr[N-2:0], 1'b0};
               quotient <= {quotient[N-2:0], take};
               cnt      <= cnt - CW'(1);
               if (cnt == '0) remainder <= rem_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_u_seqdiv16_8_restoring.sv
// Directed and random checks for u_seqdiv16_8_restoring (N=8) using a result scoreboard
// filled at stimulus time and drained on each output handshake.
module tb_u_seqdiv16_8_restoring;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;
   logic        overflow;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [7:0]  q;
      logic [7:0]  r;
      logic        dz;
      logic        ov;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   logic       stall_prev = 1'b0;
   logic [7:0] pq, pr;
   logic       pdz, pov;

   u_seqdiv16_8_restoring #(.N(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [15:0] a, input logic [7:0] b);
      exp_t e;
      e.a  = a;
      e.b  = b;
      e.dz = 1'b0;
      e.ov = 1'b0;
      if (b == 8'd0) begin
         e.q  = 8'hFF;
         e.r  = a[7:0];
         e.dz = 1'b1;
      end else if (a[15:8] >= b) begin
         e.q  = 8'hFF;
         e.r  = 8'hFF;
         e.ov = 1'b1;
      end else begin
         e.q = 8'(a / 16'(b));
         e.r = 8'(a % 16'(b));
      end
      sb.push_back(e);
   endtask

   // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
   task automatic start(input logic [15:0] a, input logic [7:0] b, input bit track, input bit hold);
      int w;
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      if (track) push_exp(a, b);
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("accept_wait", in_ready, 1);
      @(posedge clk);
      #1;
      if (!hold) begin
         in_valid = 1'b0;
         dividend = 16'($urandom);
         divisor  = 8'($urandom);
      end
   endtask

   // Edges counted with the accept edge as edge 1.
   task automatic wait_out(output int lat);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finish_op();
      @(posedge clk);
      #1;
      chk("post_hs_out_valid", out_valid, 0);
      chk("post_hs_in_ready", in_ready, 1);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            chk("in_ready_low_in_done", in_ready, 0);
            if (stall_prev) begin
               chk("stall_quotient", quotient, pq);
               chk("stall_remainder", remainder, pr);
               chk("stall_div_by_zero", div_by_zero, pdz);
               chk("stall_overflow", overflow, pov);
            end
         end
         if (out_valid && out_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               chk("quotient", quotient, mon_e.q);
               chk("remainder", remainder, mon_e.r);
               chk("div_by_zero", div_by_zero, mon_e.dz);
               chk("overflow", overflow, mon_e.ov);
               if (!mon_e.dz && !mon_e.ov) begin
                  chk("roundtrip", 16'(quotient) * 16'(mon_e.b) + 16'(remainder), mon_e.a);
                  chk("rem_lt_div", remainder < mon_e.b, 1);
               end
            end
         end
         stall_prev = out_valid && !out_ready;
         pq  = quotient;
         pr  = remainder;
         pdz = div_by_zero;
         pov = overflow;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      int lat;
      int w;
      logic [15:0] ra;
      logic [7:0]  rb;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      dividend  = '0;
      divisor   = '0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_flags", {div_by_zero, overflow}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // T1
      start(16'd1000, 8'd7, 1, 0);
      wait_out(lat);
      chk("t1_latency", lat, 9);
      finish_op();

      // T2
      start(16'd65024, 8'd255, 1, 0);
      wait_out(lat);
      chk("t2_latency", lat, 9);
      finish_op();
      start(16'd0, 8'd1, 1, 0);
      wait_out(lat);
      chk("t2_zero_latency", lat, 9);
      finish_op();

      // T3
      start(16'd1234, 8'd0, 1, 0);
      wait_out(lat);
      chk("t3_latency", lat, 1);
      finish_op();

      // T4
      start(16'h0500, 8'h05, 1, 0);
      wait_out(lat);
      chk("t4a_latency", lat, 1);
      finish_op();
      start(16'hFFFF, 8'hFF, 1, 0);
      wait_out(lat);
      chk("t4b_latency", lat, 1);
      finish_op();

      // T5: consumer stalls while a new request waits on the input side
      out_ready = 1'b0;
      start(16'd1000, 8'd7, 1, 0);
      wait_out(lat);
      chk("t5_latency", lat, 9);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      dividend = 16'd200;
      divisor  = 8'd9;
      push_exp(16'd200, 8'd9);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_in_ready_stalled", in_ready, 0);
         chk("t5_out_valid_held", out_valid, 1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t5_in_ready_at_hs", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("t5_in_ready_after_hs", in_ready, 1);
      chk("t5_out_valid_after_hs", out_valid, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_out(lat);
      chk("t5_second_latency", lat, 9);
      finish_op();

      // T6: reset in the 4th CALC cycle discards the operation
      start(16'd1000, 8'd7, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_out_valid", out_valid, 0);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_quotient", quotient, 0);
      chk("t6_remainder", remainder, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("t6_no_stale", out_valid, 0);
      @(posedge clk);
      #1;
      start(16'd100, 8'd10, 1, 0);
      wait_out(lat);
      chk("t6_latency", lat, 9);
      finish_op();

      // Random sweep, back-to-back with in_valid held high
      for (int k = 0; k < 10000; k++) begin
         ra = 16'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(31) == 0) rb = 8'd0;
         if (rb != 8'd0 && $urandom_range(1) == 0) ra[15:8] = ra[15:8] % rb;
         start(ra, rb, 1, 1);
      end
      in_valid = 1'b0;

      w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
